snake_btn_cond: RTL and testbench
=================================

# snake_btn_cond

Button conditioner for the snake game: synchronizes four raw push-button inputs, debounces them, detects presses and latches the most recent press as a one-hot request. The request is held until the game-step tick consumes it. Sits between the board pushbuttons and the direction-selection logic; its `btn_*` outputs drive that logic's `btn_up/down/left/right` inputs directly.

## Interface
- `DB_CYCLES`, default 16: consecutive cycles the synchronized input must differ from the debounced state before that state flips; legal range ≥1.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `key_up`  input  1  raw asynchronous button, 1 = pressed.
- `key_down`  input  1  raw asynchronous button, 1 = pressed.
- `key_left`  input  1  raw asynchronous button, 1 = pressed.
- `key_right`  input  1  raw asynchronous button, 1 = pressed.
- `tick`  input  1  game-step strobe, one cycle wide; consumes the held request.
- `btn_up`  output  1  latched up request.
- `btn_down`  output  1  latched down request.
- `btn_left`  output  1  latched left request.
- `btn_right`  output  1  latched right request.
- `pending`  output  1  OR of the four `btn_*` outputs.

## Operation
- Per key, independent path: 2-FF synchronizer (`s1`, `s2`), then debouncer (`stable` bit, counter of width clog2(DB_CYCLES)+1).
- Debouncer, every edge:
  - `s2 == stable`: counter is set to 0.
  - `s2 != stable` and counter == DB_CYCLES-1: `stable` is set to `s2` and counter to 0.
  - Otherwise the counter increments.
- Press event: `stable` rises 0→1 on this edge. The event is computed from the next-state value, so the latch updates on the same edge.
- Release (`stable` 1→0) generates no event. A release does not clear the latch.
- Latch (4-bit one-hot, or all zero), priority per edge:
  1. Any press event: latch is loaded with the one-hot of the highest-priority event (up > down > left > right). This overwrites any previous request and applies even if `tick` is high.
  2. Else, if `tick` is high: latch is cleared.
  3. Else: latch holds.
- `btn_*` come straight from the latch register; `pending` = OR of latch bits.
- During the cycle `tick` is high, `btn_*` still show the request. The consumer samples them in that cycle.
- Reset: `s1`, `s2`, `stable`, counters and latch all go to 0.
  - All outputs read 0 after the reset edge.
  - A key held through reset is re-detected as a fresh press once reset is released and the debounce completes.

## Timing
- Numbering: key rises before edge 1 and stays high.
  - `s1` = 1 after edge 1.
  - `s2` = 1 after edge 2.
  - `stable` and `btn_*` = 1 after edge DB_CYCLES+2.
- Release debounce takes the same DB_CYCLES+2 edges.
- Glitch shorter than DB_CYCLES cycles at `s2`: counter returns to 0 and `stable` is unchanged.
- `tick` alone clears the request at that edge; `btn_*` and `pending` read 0 from the next cycle.
- `tick` and a press event on the same edge: the new press is latched and the old request is dropped.
- Two keys whose `stable` rises on the same edge: only the higher-priority one is latched.

## Configuration
- `SNAKE_BTN_DEBOUNCE_EN` defined: debouncer exactly as above; press latency DB_CYCLES+2 edges.
- Not defined: debouncer removed.
  - `stable` <= `s2` every edge; no counters are instantiated and DB_CYCLES is ignored.
  - Press latency is 3 edges.
  - Latch, priority, `tick` and reset behaviour are unchanged.

## Test plan
All scenarios use DB_CYCLES=4 and `SNAKE_BTN_DEBOUNCE_EN` defined unless stated.
- **Basic press:** `key_up` high before edge 1, held, `tick`=0 → `btn_up`=1 and `pending`=1 after edge 6, 0 before; held while the key is released.
- **Glitch rejection:** `key_left` pulsed high for 3 cycles → `btn_left` stays 0; internal counter returns to 0.
- **Tick consume:** request `btn_down` held, `tick` for one cycle → `btn_down`=1 during the tick cycle, 0 from the next cycle.
- **Simultaneous press:** `key_left` and `key_right` rise in the same cycle → only `btn_left`=1 after edge 6.
- **Tick collides with press:** latch holds `btn_up`; `key_right` debounced rise coincides with `tick` → after that edge `btn_right`=1, `btn_up`=0.
- **Reset mid-operation:** `rst` asserted at edge 4 of a `key_down` press → all outputs 0 after that edge; with the key still held and `rst` deasserted, `btn_down`=1 exactly 6 edges after the first non-reset edge. Repeat with the macro undefined → latency 3 edges.

Source files
------------

// File: rtl/snake_btn_cond.sv
// snake_btn_cond: synchronizes, debounces and latches four buttons as a one-hot request
// Debouncer is built only when SNAKE_BTN_DEBOUNCE_EN is defined; otherwise stable follows s2.
module snake_btn_cond #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    input  logic tick,
    output logic btn_up,
    output logic btn_down,
    output logic btn_left,
    output logic btn_right,
    output logic pending
);
    logic [3:0] key, s1, s2, stable, stable_nx, press, req, req_nx;
    assign key = {key_right, key_left, key_down, key_up};
`ifdef SNAKE_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES) + 1;
    logic [3:0][CW-1:0] cnt, cnt_nx;
    always_comb begin
        stable_nx = stable;
        cnt_nx = '0;
        for (int i = 0; i < 4; i++) begin
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CW'(DB_CYCLES - 1)) stable_nx[i] = s2[i];
                else cnt_nx[i] = cnt[i] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) cnt <= rst ? '0 : cnt_nx;
`else
    logic unused_db;
    assign unused_db = (DB_CYCLES > 0);
    assign stable_nx = s2;
`endif
    // x & -x isolates the lowest set bit, which is up (highest priority)
    assign press  = stable_nx & ~stable;
    assign req_nx = |press ? (press & (~press + 4'd1)) : tick ? 4'd0 : req;
    always_ff @(posedge clk) begin
        s1     <= rst ? '0 : key;
        s2     <= rst ? '0 : s1;
        stable <= rst ? '0 : stable_nx;
        req    <= rst ? '0 : req_nx;
    end
    assign {btn_right, btn_left, btn_down, btn_up} = req;
    assign pending = |req;
endmodule

// File: tb/tb_snake_btn_cond.sv
// tb_snake_btn_cond: directed checks of press latency, glitch, tick, priority and reset
module tb_snake_btn_cond;
    localparam int DB = 4;
`ifdef SNAKE_BTN_DEBOUNCE_EN
    localparam int LAT = DB + 2;
    localparam logic GLITCH_PASSES = 1'b0;
`else
    localparam int LAT = 3;
    localparam logic GLITCH_PASSES = 1'b1;
`endif
    localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000, NO = 4'b0000;
    logic clk = 0, rst = 1, tick = 0;
    logic key_up = 0, key_down = 0, key_left = 0, key_right = 0;
    logic btn_up, btn_down, btn_left, btn_right, pending;
    logic [4:0] outs;
    int total = 0, bad = 0;
    assign outs = {pending, btn_right, btn_left, btn_down, btn_up};
    always #5 clk = ~clk;
    snake_btn_cond #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pending(pending)
    );
    function automatic logic [4:0] ex(input logic [3:0] o);
        return {|o, o};
    endfunction
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic clear_req();
        tick = 1;
        step(1);
        tick = 0;
    endtask
    initial begin
        step(2);
        check("reset", outs, ex(NO));
        rst = 0;
        step(1);
        check("idle", outs, ex(NO));
        key_up = 1;
        for (int e = 1; e <= LAT; e++) begin
            step(1);
            check($sformatf("press_up_e%0d", e), outs, e == LAT ? ex(UP) : ex(NO));
        end
        key_up = 0;
        step(LAT + 3);
        check("hold_after_release", outs, ex(UP));
        key_down = 1;
        step(LAT);
        check("down_overwrites", outs, ex(DN));
        key_down = 0;
        step(LAT + 2);
        tick = 1;
        check("visible_during_tick", outs, ex(DN));
        step(1);
        tick = 0;
        check("cleared_after_tick", outs, ex(NO));
        step(2);
        check("stays_clear", outs, ex(NO));
        key_left = 1;
        step(3);
        key_left = 0;
        step(LAT + 4);
        check("glitch_left", outs, GLITCH_PASSES ? ex(LF) : ex(NO));
        clear_req();
        check("glitch_clear", outs, ex(NO));
        key_left = 1;
        key_right = 1;
        step(LAT - 1);
        check("simul_before", outs, ex(NO));
        step(1);
        check("simul_left_wins", outs, ex(LF));
        key_left = 0;
        key_right = 0;
        step(LAT + 2);
        clear_req();
        key_up = 1;
        step(LAT);
        key_up = 0;
        step(LAT + 2);
        check("collide_setup", outs, ex(UP));
        key_right = 1;
        step(LAT - 1);
        check("collide_pre", outs, ex(UP));
        tick = 1;
        step(1);
        tick = 0;
        check("collide_right", outs, ex(RT));
        key_right = 0;
        step(LAT + 2);
        clear_req();
        check("collide_clear", outs, ex(NO));
        key_down = 1;
        step(3);
        rst = 1;
        step(1);
        check("reset_mid", outs, ex(NO));
        rst = 0;
        for (int e = 1; e <= LAT; e++) begin
            step(1);
            check($sformatf("rst_redetect_e%0d", e), outs, e == LAT ? ex(DN) : ex(NO));
        end
        key_down = 0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
